// File: rtl/hazard_scoreboard_pkg.sv
// Shared sizing constants and types for the register-write hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int NUM_REGS    = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int CNT_W       = 2;
  localparam int STALL_CNT_W = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    REASON_NONE     = 2'b00,
    REASON_LOAD_USE = 2'b01,
    REASON_LONG     = 2'b10,
    REASON_FULL     = 2'b11
  } stall_reason_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode / EX-kill / writeback signals seen by the scoreboard, plus its stall and status outputs.
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic                   id_valid;
  reg_addr_t              id_rs1;
  reg_addr_t              id_rs2;
  logic                   id_rs1_used;
  logic                   id_rs2_used;
  reg_addr_t              id_rd;
  logic                   id_reg_write;
  logic                   id_is_load;
  logic                   id_is_long;
  logic                   ex_kill;
  logic                   wb_valid;
  logic                   wb_reg_write;
  logic                   wb_is_long;
  reg_addr_t              wb_rd;
  logic                   stall;
  stall_reason_e          stall_reason;
  logic                   busy;
  logic [STALL_CNT_W-1:0] stall_cycles;
  logic                   sb_error;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_write, id_is_load, id_is_long, ex_kill,
           wb_valid, wb_reg_write, wb_is_long, wb_rd,
    input  stall, stall_reason, busy, stall_cycles, sb_error
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_write, id_is_load, id_is_long, ex_kill,
           wb_valid, wb_reg_write, wb_is_long, wb_rd,
    output stall, stall_reason, busy, stall_cycles, sb_error
  );

endinterface

// File: rtl/hazard_scoreboard_sb_counter.sv
// Small outstanding-write counter: one increment and two decrement sources net in a single
// step; going below zero clamps at zero and raises underflow for that cycle.
module sb_counter
  import hazard_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec_a,
  input  logic             dec_b,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  logic [CNT_W:0]   up;
  logic [CNT_W:0]   down;
  logic [CNT_W:0]   diff;
  logic [CNT_W-1:0] count_next;

  assign up   = {1'b0, count} + (CNT_W+1)'(inc);
  assign down = (CNT_W+1)'(dec_a) + (CNT_W+1)'(dec_b);
  assign diff = up - down;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    underflow  = 1'b0;
    count_next = diff[CNT_W-1:0];
    if (up < down) begin
      underflow  = 1'b1;
      count_next = '0;
    end else if (diff[CNT_W]) begin
      count_next = '1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count_next;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order issue scoreboard: tracks outstanding (and long-latency) writes per register and
// stalls decode on load-use, pending long results, or a saturated per-register counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave bus
);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0][CNT_W-1:0] lcnt;
  logic [NUM_REGS-1:1] inc, linc, wb_dec, wb_ldec, kill_dec, kill_ldec;
  logic [NUM_REGS-1:1] cnt_uf, lcnt_uf;

  logic                   ex_v;
  reg_addr_t              ex_rd;
  logic                   ex_load;
  logic                   ex_long;
  logic                   wb_fire;
  logic                   kill_fire;
  logic                   track_issue;
  logic                   rel_rs1;
  logic                   rel_rs2;
  logic                   dec_on_rd;
  logic                   load_use;
  logic                   long_haz;
  logic                   cnt_full;
  logic                   stall;
  stall_reason_e          reason;
  logic [STALL_CNT_W-1:0] stall_cycles;
  logic                   sb_error;

  assign wb_fire     = bus.wb_valid & bus.wb_reg_write & (bus.wb_rd != '0);
  assign kill_fire   = bus.ex_kill & ex_v;
  assign track_issue = bus.id_valid & ~stall & bus.id_reg_write & (bus.id_rd != '0);

  // A long writeback retiring this cycle releases its readers without an extra bubble.
  assign rel_rs1 = wb_fire & bus.wb_is_long & (bus.wb_rd == bus.id_rs1);
  assign rel_rs2 = wb_fire & bus.wb_is_long & (bus.wb_rd == bus.id_rs2);

  always_comb begin
    load_use  = ex_v & ex_load & ~bus.ex_kill &
                ((bus.id_rs1_used & (bus.id_rs1 == ex_rd)) |
                 (bus.id_rs2_used & (bus.id_rs2 == ex_rd)));
    long_haz  = (bus.id_rs1_used & (lcnt[bus.id_rs1] > CNT_W'(rel_rs1))) |
                (bus.id_rs2_used & (lcnt[bus.id_rs2] > CNT_W'(rel_rs2)));
    dec_on_rd = (wb_fire & (bus.wb_rd == bus.id_rd)) | (kill_fire & (ex_rd == bus.id_rd));
    cnt_full  = bus.id_reg_write & (bus.id_rd != '0) & (cnt[bus.id_rd] == '1) & ~dec_on_rd;
    stall     = bus.id_valid & (load_use | long_haz | cnt_full);
    reason    = REASON_NONE;
    if (stall) begin
      if (load_use)      reason = REASON_LOAD_USE;
      else if (long_haz) reason = REASON_LONG;
      else               reason = REASON_FULL;
    end
  end

  // Register 0 is hardwired and never tracked.
  assign cnt[0]  = '0;
  assign lcnt[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    localparam reg_addr_t R = reg_addr_t'(r);

    assign inc[r]       = track_issue & (bus.id_rd == R);
    assign linc[r]      = inc[r] & bus.id_is_long;
    assign wb_dec[r]    = wb_fire & (bus.wb_rd == R);
    assign wb_ldec[r]   = wb_dec[r] & bus.wb_is_long;
    assign kill_dec[r]  = kill_fire & (ex_rd == R);
    assign kill_ldec[r] = kill_dec[r] & ex_long;

    sb_counter u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc[r]),
      .dec_a     (wb_dec[r]),
      .dec_b     (kill_dec[r]),
      .count     (cnt[r]),
      .underflow (cnt_uf[r])
    );

    sb_counter u_lcnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (linc[r]),
      .dec_a     (wb_ldec[r]),
      .dec_b     (kill_ldec[r]),
      .count     (lcnt[r]),
      .underflow (lcnt_uf[r])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v         <= 1'b0;
      ex_rd        <= '0;
      ex_load      <= 1'b0;
      ex_long      <= 1'b0;
      stall_cycles <= '0;
      sb_error     <= 1'b0;
    end else begin
      ex_v    <= track_issue;
      ex_rd   <= track_issue ? bus.id_rd : '0;
      ex_load <= track_issue & bus.id_is_load;
      ex_long <= track_issue & bus.id_is_long;
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      sb_error <= sb_error | (|cnt_uf) | (|lcnt_uf);
    end
  end

  assign bus.stall        = stall;
  assign bus.stall_reason = reason;
  assign bus.busy         = |cnt;
  assign bus.stall_cycles = stall_cycles;
  assign bus.sb_error     = sb_error;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: directed vector table, multi-cycle corner sequences, and random traffic
// checked against an array-based reference model.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if bus ();

  hazard_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       lg;
    logic       kill;
    logic       wbv;
    logic       wbw;
    logic [4:0] wbrd;
    logic       wbl;
    logic       e_stall;
    logic [1:0] e_reason;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state: plain integer counts per architectural register.
  int   m_cnt [32];
  int   m_lcnt[32];
  logic m_ex_v;
  int   m_ex_rd;
  logic m_ex_load;
  logic m_ex_long;
  int   m_sc;
  logic m_err;

  vec_t tbl[$];

  function automatic vec_t idle();
    vec_t x;
    x = '{default: '0};
    return x;
  endfunction

  function automatic vec_t id_op(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                 input logic u2, input logic [4:0] rd, input logic rw,
                                 input logic ld, input logic lg);
    vec_t x;
    x = idle();
    x.v = 1'b1; x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2;
    x.rd = rd; x.rw = rw; x.ld = ld; x.lg = lg;
    return x;
  endfunction

  function automatic vec_t with_wb(input vec_t x, input logic [4:0] rd, input logic lg);
    vec_t y;
    y = x;
    y.wbv = 1'b1; y.wbw = 1'b1; y.wbrd = rd; y.wbl = lg;
    return y;
  endfunction

  function automatic vec_t with_kill(input vec_t x);
    vec_t y;
    y = x;
    y.kill = 1'b1;
    return y;
  endfunction

  function automatic vec_t no_valid(input vec_t x);
    vec_t y;
    y = x;
    y.v = 1'b0;
    return y;
  endfunction

  function automatic vec_t exp_out(input vec_t x, input logic st, input logic [1:0] why,
                                   input logic bz, input logic er);
    vec_t y;
    y = x;
    y.e_stall = st; y.e_reason = why; y.e_busy = bz; y.e_err = er;
    return y;
  endfunction

  task automatic drive(input vec_t x);
    bus.id_valid     = x.v;
    bus.id_rs1       = x.rs1;
    bus.id_rs1_used  = x.u1;
    bus.id_rs2       = x.rs2;
    bus.id_rs2_used  = x.u2;
    bus.id_rd        = x.rd;
    bus.id_reg_write = x.rw;
    bus.id_is_load   = x.ld;
    bus.id_is_long   = x.lg;
    bus.ex_kill      = x.kill;
    bus.wb_valid     = x.wbv;
    bus.wb_reg_write = x.wbw;
    bus.wb_rd        = x.wbrd;
    bus.wb_is_long   = x.wbl;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic e_stall, input logic [1:0] e_reason,
                           input logic e_busy, input logic [15:0] e_sc, input logic e_err);
    check({tag, ".stall"},        32'(bus.stall),        32'(e_stall));
    check({tag, ".stall_reason"}, 32'(bus.stall_reason), 32'(e_reason));
    check({tag, ".busy"},         32'(bus.busy),         32'(e_busy));
    check({tag, ".stall_cycles"}, 32'(bus.stall_cycles), 32'(e_sc));
    check({tag, ".sb_error"},     32'(bus.sb_error),     32'(e_err));
  endtask

  task automatic do_reset();
    drive(idle());
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) begin
      m_cnt[r]  = 0;
      m_lcnt[r] = 0;
    end
    m_ex_v = 1'b0; m_ex_rd = 0; m_ex_load = 1'b0; m_ex_long = 1'b0;
    m_sc = 0; m_err = 1'b0;
  endfunction

  function automatic void model_outputs(input vec_t x, output logic st, output logic [1:0] why);
    logic wb_fire, kill_fire, lu, lh, full, dec_rd;
    int   eff1, eff2;
    wb_fire   = x.wbv && x.wbw && (x.wbrd != 0);
    kill_fire = x.kill && m_ex_v;
    eff1 = m_lcnt[x.rs1] - ((wb_fire && x.wbl && x.wbrd == x.rs1) ? 1 : 0);
    eff2 = m_lcnt[x.rs2] - ((wb_fire && x.wbl && x.wbrd == x.rs2) ? 1 : 0);
    lu = m_ex_v && m_ex_load && !x.kill &&
         ((x.u1 && int'(x.rs1) == m_ex_rd) || (x.u2 && int'(x.rs2) == m_ex_rd));
    lh = (x.u1 && eff1 > 0) || (x.u2 && eff2 > 0);
    dec_rd = (wb_fire && x.wbrd == x.rd) || (kill_fire && m_ex_rd == int'(x.rd));
    full = x.rw && (x.rd != 0) && (m_cnt[x.rd] == 3) && !dec_rd;
    st  = x.v && (lu || lh || full);
    why = !st ? 2'b00 : lu ? 2'b01 : lh ? 2'b10 : 2'b11;
  endfunction

  function automatic void model_step(input vec_t x, input logic st);
    int   d[32];
    int   dl[32];
    int   n;
    logic wb_fire, kill_fire, track;
    wb_fire   = x.wbv && x.wbw && (x.wbrd != 0);
    kill_fire = x.kill && m_ex_v;
    track     = x.v && !st && x.rw && (x.rd != 0);
    for (int r = 0; r < 32; r++) begin
      d[r] = 0; dl[r] = 0;
    end
    if (track)     begin d[x.rd]++;     if (x.lg)      dl[x.rd]++;     end
    if (wb_fire)   begin d[x.wbrd]--;   if (x.wbl)     dl[x.wbrd]--;   end
    if (kill_fire) begin d[m_ex_rd]--;  if (m_ex_long) dl[m_ex_rd]--;  end
    for (int r = 1; r < 32; r++) begin
      n = m_cnt[r] + d[r];
      if (n < 0) begin n = 0; m_err = 1'b1; end
      if (n > 3) n = 3;
      m_cnt[r] = n;
      n = m_lcnt[r] + dl[r];
      if (n < 0) begin n = 0; m_err = 1'b1; end
      if (n > 3) n = 3;
      m_lcnt[r] = n;
    end
    m_ex_v    = track;
    m_ex_rd   = track ? int'(x.rd) : 0;
    m_ex_load = track && x.ld;
    m_ex_long = track && x.lg;
    if (st && m_sc < 65535) m_sc++;
  endfunction

  function automatic logic model_busy();
    logic b;
    b = 1'b0;
    for (int r = 0; r < 32; r++) if (m_cnt[r] != 0) b = 1'b1;
    return b;
  endfunction

  function automatic vec_t rand_vec();
    vec_t x;
    int   q[$];
    x = idle();
    x.v    = ($urandom_range(0, 3) != 0);
    x.rs1  = 5'($urandom_range(0, 7));
    x.u1   = 1'($urandom_range(0, 1));
    x.rs2  = 5'($urandom_range(0, 7));
    x.u2   = 1'($urandom_range(0, 1));
    x.rd   = 5'($urandom_range(0, 7));
    x.rw   = ($urandom_range(0, 9) < 7);
    x.ld   = ($urandom_range(0, 9) < 3);
    x.lg   = !x.ld && ($urandom_range(0, 9) < 2);
    x.kill = ($urandom_range(0, 9) == 0);
    if ($urandom_range(0, 9) < 4) begin
      x.wbv = 1'b1;
      x.wbw = ($urandom_range(0, 9) != 0);
      for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 9) != 0) begin
        x.wbrd = 5'(q[$urandom_range(0, q.size() - 1)]);
        x.wbl  = (m_lcnt[x.wbrd] > 0);
      end else begin
        x.wbrd = 5'($urandom_range(0, 7));
        x.wbl  = 1'($urandom_range(0, 1));
      end
    end
    return x;
  endfunction

  initial begin
    vec_t       cur;
    logic       est;
    logic [1:0] ereason;
    int         exp_sc;

    // Directed table, starting from a clean reset.
    tbl.push_back(exp_out(id_op(0, 0, 0, 0, 5, 1, 1, 0), 0, 2'd0, 0, 0));              // load x5
    tbl.push_back(exp_out(id_op(5, 1, 5, 1, 6, 1, 0, 0), 1, 2'd1, 1, 0));              // load-use
    tbl.push_back(exp_out(id_op(5, 1, 5, 1, 6, 1, 0, 0), 0, 2'd0, 1, 0));              // issues
    tbl.push_back(exp_out(with_wb(idle(), 5, 0), 0, 2'd0, 1, 0));
    tbl.push_back(exp_out(with_wb(idle(), 6, 0), 0, 2'd0, 1, 0));
    tbl.push_back(exp_out(id_op(0, 0, 0, 0, 7, 1, 0, 1), 0, 2'd0, 0, 0));              // div x7
    tbl.push_back(exp_out(id_op(7, 1, 0, 0, 8, 1, 0, 0), 1, 2'd2, 1, 0));
    tbl.push_back(exp_out(id_op(7, 1, 0, 0, 8, 1, 0, 0), 1, 2'd2, 1, 0));
    tbl.push_back(exp_out(with_wb(id_op(7, 1, 0, 0, 8, 1, 0, 0), 7, 1), 0, 2'd0, 1, 0));
    tbl.push_back(exp_out(with_wb(idle(), 8, 0), 0, 2'd0, 1, 0));
    tbl.push_back(exp_out(id_op(0, 0, 0, 0, 3, 1, 0, 0), 0, 2'd0, 0, 0));              // x3 #1
    tbl.push_back(exp_out(id_op(0, 0, 0, 0, 3, 1, 0, 0), 0, 2'd0, 1, 0));              // x3 #2
    tbl.push_back(exp_out(id_op(0, 0, 0, 0, 3, 1, 0, 0), 0, 2'd0, 1, 0));              // x3 #3
    tbl.push_back(exp_out(id_op(0, 0, 0, 0, 3, 1, 0, 0), 1, 2'd3, 1, 0));              // full
    tbl.push_back(exp_out(with_wb(id_op(0, 0, 0, 0, 3, 1, 0, 0), 3, 0), 0, 2'd0, 1, 0));
    tbl.push_back(exp_out(with_wb(idle(), 3, 0), 0, 2'd0, 1, 0));
    tbl.push_back(exp_out(with_wb(idle(), 3, 0), 0, 2'd0, 1, 0));
    tbl.push_back(exp_out(with_wb(idle(), 3, 0), 0, 2'd0, 1, 0));
    tbl.push_back(exp_out(id_op(0, 0, 0, 0, 9, 1, 1, 0), 0, 2'd0, 0, 0));              // load x9
    tbl.push_back(exp_out(with_kill(id_op(9, 1, 0, 0, 0, 0, 0, 0)), 0, 2'd0, 1, 0));   // killed
    tbl.push_back(exp_out(idle(), 0, 2'd0, 0, 0));
    tbl.push_back(exp_out(id_op(0, 0, 0, 0, 12, 1, 1, 0), 0, 2'd0, 0, 0));             // load x12
    tbl.push_back(exp_out(no_valid(id_op(12, 1, 0, 0, 0, 0, 0, 0)), 0, 2'd0, 1, 0));
    tbl.push_back(exp_out(with_wb(idle(), 12, 0), 0, 2'd0, 1, 0));
    tbl.push_back(exp_out(with_kill(idle()), 0, 2'd0, 0, 0));                          // stray kill
    tbl.push_back(exp_out(id_op(0, 0, 0, 0, 0, 1, 1, 1), 0, 2'd0, 0, 0));              // x0 write
    tbl.push_back(exp_out(id_op(0, 1, 0, 1, 0, 1, 0, 0), 0, 2'd0, 0, 0));              // x0 read
    tbl.push_back(exp_out(idle(), 0, 2'd0, 0, 0));

    drive(idle());
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("in_reset", 1'b0, 2'd0, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    exp_sc = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check_all($sformatf("tbl%0d", i), tbl[i].e_stall, tbl[i].e_reason, tbl[i].e_busy,
                16'(exp_sc), tbl[i].e_err);
      if (tbl[i].e_stall) exp_sc++;
    end

    // Writeback with nothing outstanding raises a sticky error.
    @(negedge clk); drive(with_wb(idle(), 4, 0)); #1;
    check("err_before_wb", 32'(bus.sb_error), 32'd0);
    @(negedge clk); drive(idle()); #1;
    check("err_set", 32'(bus.sb_error), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("err_sticky", 32'(bus.sb_error), 32'd1);

    // Asynchronous reset in the middle of a load-use stall.
    @(negedge clk); drive(id_op(0, 0, 0, 0, 5, 1, 1, 0));
    @(negedge clk); drive(id_op(5, 1, 0, 0, 6, 1, 0, 0)); #1;
    check("midstall_stall", 32'(bus.stall), 32'd1);
    rst = 1'b1;
    #1;
    check_all("midstall_rst", 1'b0, 2'd0, 1'b0, 16'd0, 1'b0);
    @(negedge clk); rst = 1'b0; drive(idle());

    // Reset discards an outstanding write; its later writeback is an error.
    @(negedge clk); drive(id_op(0, 0, 0, 0, 11, 1, 0, 0));
    @(negedge clk); drive(idle()); #1;
    check("x11_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("x11_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk); rst = 1'b0; drive(with_wb(idle(), 11, 0));
    @(negedge clk); drive(idle()); #1;
    check("x11_orphan_err", 32'(bus.sb_error), 32'd1);
    do_reset();
    #1;
    check("err_cleared", 32'(bus.sb_error), 32'd0);

    // Long-held stall saturates the stall-cycle counter.
    @(negedge clk); drive(id_op(0, 0, 0, 0, 7, 1, 0, 1));
    @(negedge clk); drive(id_op(7, 1, 0, 0, 8, 1, 0, 0)); #1;
    check("hold_stall", 32'(bus.stall), 32'd1);
    repeat (70000) @(posedge clk);
    @(negedge clk); #1;
    check_all("saturate", 1'b1, 2'd2, 1'b1, 16'hFFFF, 1'b0);
    do_reset();

    // Random traffic against the reference model.
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        model_reset();
        continue;
      end
      cur = rand_vec();
      drive(cur);
      #1;
      model_outputs(cur, est, ereason);
      check_all($sformatf("rnd%0d", c), est, ereason, model_busy(), 16'(m_sc), m_err);
      @(posedge clk);
      model_step(cur, est);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
